// File: rtl/rns2bin_mrc_seq.sv
// Sequential mixed-radix residue-to-binary converter: one mixed-radix digit per clock, valid/ready on both sides.
// Optional macro RNS2BIN_RANGE_CHECK_EN flags any residue >= its modulus, raising err and zeroing N in DONE.
module rns2bin_mrc_seq #(
  parameter int N_MOD = 4,
  parameter int MOD_W = 5,
  parameter int OUT_W = 17,
  parameter logic [N_MOD*(MOD_W+1)-1:0] MODULI = {6'd5, 6'd21, 6'd31, 6'd32},
  parameter logic [N_MOD*MOD_W-1:0]     INV    = {5'd3, 5'd17, 5'd1, 5'd0}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_MOD*MOD_W-1:0] x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       N,
  output logic                   err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int ST_W = $clog2(N_MOD);

  logic [1:0]                   state_reg;
  logic [ST_W-1:0]              stage_reg;
  logic [OUT_W-1:0]             y_reg, m_reg, n_reg;
  logic [OUT_W-1:0]             y_next, m_next;
  logic [(N_MOD-1)*MOD_W-1:0]   x_reg;
  logic [MOD_W-1:0]             d_arr [1:N_MOD-1];
  logic [MOD_W-1:0]             d_sel;
  logic [MOD_W:0]               m_sel;

  // Each stage owns a constant-modulus reducer; only the active stage's digit is used.
  genvar gi;
  generate
    for (gi = 1; gi < N_MOD; gi++) begin : g_digit
      localparam logic [MOD_W:0]   MI    = MODULI[gi*(MOD_W+1) +: (MOD_W+1)];
      localparam logic [MOD_W-1:0] INV_I = INV[gi*MOD_W +: MOD_W];
      logic [MOD_W:0]   xi, r, diff;
      logic [2*MOD_W:0] prod;
      assign xi       = {1'b0, x_reg[(gi-1)*MOD_W +: MOD_W]};
      assign r        = (MOD_W+1)'(y_reg % OUT_W'(MI));
      assign diff     = (xi >= r) ? (xi - r) : (xi + MI - r);
      assign prod     = (2*MOD_W+1)'(diff) * (2*MOD_W+1)'(INV_I);
      assign d_arr[gi] = MOD_W'(prod % (2*MOD_W+1)'(MI));
    end
  endgenerate

  always_comb begin
    d_sel = '0;
    m_sel = '0;
    for (int i = 1; i < N_MOD; i++) begin
      if (stage_reg == ST_W'(i)) begin
        d_sel = d_arr[i];
        m_sel = MODULI[i*(MOD_W+1) +: (MOD_W+1)];
      end
    end
  end

  // Y stays below M, so modular truncation to OUT_W never loses a result bit.
  assign y_next = y_reg + OUT_W'(d_sel) * m_reg;
  assign m_next = m_reg * OUT_W'(m_sel);

`ifdef RNS2BIN_RANGE_CHECK_EN
  logic [N_MOD-1:0] oor;
  logic             err_reg;
  for (gi = 0; gi < N_MOD; gi++) begin : g_range
    assign oor[gi] = {1'b0, x[gi*MOD_W +: MOD_W]} >= MODULI[gi*(MOD_W+1) +: (MOD_W+1)];
  end
  assign err = err_reg && (state_reg == DONE);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      stage_reg <= '0;
      y_reg     <= '0;
      m_reg     <= '0;
      x_reg     <= '0;
      n_reg     <= '0;
`ifdef RNS2BIN_RANGE_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg     <= x[N_MOD*MOD_W-1:MOD_W];
            y_reg     <= OUT_W'(x[MOD_W-1:0]);
            m_reg     <= OUT_W'(MODULI[MOD_W:0]);
            stage_reg <= ST_W'(1);
            state_reg <= CALC;
`ifdef RNS2BIN_RANGE_CHECK_EN
            err_reg   <= |oor;
`endif
          end
        end
        CALC: begin
          y_reg     <= y_next;
          m_reg     <= m_next;
          stage_reg <= stage_reg + ST_W'(1);
          if (stage_reg == ST_W'(N_MOD - 1)) begin
            state_reg <= DONE;
`ifdef RNS2BIN_RANGE_CHECK_EN
            n_reg     <= err_reg ? '0 : y_next;
`else
            n_reg     <= y_next;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
`ifdef RNS2BIN_RANGE_CHECK_EN
            err_reg   <= 1'b0;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !reset;
  assign out_valid = (state_reg == DONE);
  assign N         = n_reg;

endmodule

// File: tb/tb_rns2bin_mrc_seq.sv
// Scoreboard bench for rns2bin_mrc_seq (moduli 32,31,21,5); expected values come from spec constants or X % m_i.
module tb_rns2bin_mrc_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [19:0] x = '0;
  logic        in_ready, out_valid, err;
  logic [16:0] n;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  time last_accept = 0;

  rns2bin_mrc_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .N(n), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [19:0] res_of(input int v);
    return {5'(v % 5), 5'(v % 21), 5'(v % 31), 5'(v % 32)};
  endfunction

  // Drive one word and hold it until accepted (bounded); called at posedge+1, returns at posedge+1.
  task automatic send(input logic [19:0] xv, input logic [16:0] expv, input bit push);
    bit done = 0;
    x = xv;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    x = 20'($urandom);
    if (done) begin
      last_accept = $time;
      if (push) exp_q.push_back(expv);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1 within 40 cycles", in_ready);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset;
    bit seen = 0;
    reset = 1'b1;
    in_valid = 1'b1;
    x = pk(25, 7, 18, 0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || n !== 17'd0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: in_ready=%b out_valid=%b N=%0d err=%b required 0 0 0 0",
                 in_ready, out_valid, n, err);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_wins_capture: out_valid=1 required 0 (word captured during reset)");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [16:0] e;
    out_ready = 1'b1;
    send(pk(25, 7, 18, 0), 17'd12345, 1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL calc_flags: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (dut.y_reg !== 17'd441) begin
      errors++;
      $display("FAIL y_stage1: Y=%0d required 441", dut.y_reg);
    end
    @(negedge clk);
    checks++;
    if (dut.y_reg !== 17'd12345 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL y_stage2: Y=%0d out_valid=%b required 12345 0", dut.y_reg, out_valid);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || n !== e || err !== 1'b0) begin
      errors++;
      $display("FAIL latency_result: out_valid=%b N=%0d err=%b required 1 %0d 0", out_valid, n, err, e);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || n !== 17'd12345) begin
      errors++;
      $display("FAIL after_deliver: out_valid=%b in_ready=%b N=%0d required 0 1 12345",
               out_valid, in_ready, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_boundaries;
    logic [19:0] vecs [3];
    logic [16:0] exps [3];
    logic [16:0] e;
    bit ok;
    vecs[0] = pk(31, 30, 20, 4); exps[0] = 17'd104159;
    vecs[1] = pk(0, 0, 0, 0);    exps[1] = 17'd0;
    vecs[2] = pk(1, 1, 1, 1);    exps[2] = 17'd1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(vecs[k], exps[k], 1);
      wait_valid(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL boundary_%0d_timeout: out_valid=0 required 1", k);
      end else begin
        e = exp_q.pop_front();
        if (n !== e || err !== 1'b0) begin
          errors++;
          $display("FAIL boundary_%0d: N=%0d err=%b required %0d 0", k, n, err, e);
        end
      end
      @(posedge clk);
      #1;
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    logic [16:0] e;
    bit ok;
    bit seen = 0;
    out_ready = 1'b0;
    send(pk(25, 7, 18, 0), 17'd12345, 1);
    wait_valid(ok);
    e = exp_q.pop_front();
    in_valid = 1'b1;
    x = pk(1, 1, 1, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (!ok || out_valid !== 1'b1 || n !== e || in_ready !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b N=%0d in_ready=%b err=%b required 1 %0d 0 0",
                 c, out_valid, n, in_ready, err, e);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL ignored_in_valid: out_valid=1 required 0 (word accepted while busy)");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_calc;
    logic [16:0] e;
    bit ok;
    bit seen = 0;
    out_ready = 1'b1;
    send(pk(25, 7, 18, 0), 17'd12345, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_discard: out_valid=1 required 0");
    end
    @(posedge clk);
    #1;
    send(pk(31, 30, 20, 4), 17'd104159, 1);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_reset_next_timeout: out_valid=0 required 1");
    end else begin
      e = exp_q.pop_front();
      if (n !== e) begin
        errors++;
        $display("FAIL mid_reset_next: N=%0d required %0d", n, e);
      end
    end
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    fork
      begin
        time prev;
        int v;
        for (int k = 0; k < 6; k++) begin
          v = (k == 0) ? 104159 : int'($urandom_range(0, 104159));
          prev = last_accept;
          send(res_of(v), 17'(v), 1);
          if (k > 0) begin
            checks++;
            if (last_accept - prev != 50) begin
              errors++;
              $display("FAIL throughput_%0d: accept spacing=%0t required 50", k, last_accept - prev);
            end
          end
        end
      end
      begin
        bit ok;
        logic [16:0] e;
        for (int k = 0; k < 6; k++) begin
          wait_valid(ok);
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL b2b_%0d_timeout: out_valid=0 required 1", k);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_%0d_early: out_valid=1 with no pending word", k);
          end else begin
            e = exp_q.pop_front();
            if (n !== e) begin
              errors++;
              $display("FAIL b2b_%0d: N=%0d required %0d", k, n, e);
            end
          end
          @(posedge clk);
          #1;
        end
      end
    join
    exp_q.delete();
  endtask

  task automatic test_range_check;
    bit ok;
    out_ready = 1'b1;
    send(pk(25, 7, 21, 0), 17'd0, 0);
    wait_valid(ok);
    checks++;
`ifdef RNS2BIN_RANGE_CHECK_EN
    if (!ok || err !== 1'b1 || n !== 17'd0) begin
      errors++;
      $display("FAIL range_err: valid=%b err=%b N=%0d required 1 1 0", ok, err, n);
    end
`else
    if (!ok || err !== 1'b0) begin
      errors++;
      $display("FAIL range_tied: valid=%b err=%b required 1 0", ok, err);
    end
`endif
    @(posedge clk);
    #1;
    send(pk(25, 7, 18, 0), 17'd12345, 0);
    wait_valid(ok);
    checks++;
    if (!ok || err !== 1'b0 || n !== 17'd12345) begin
      errors++;
      $display("FAIL range_recover: valid=%b err=%b N=%0d required 1 0 12345", ok, err, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_range_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
